// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider with a start/done handshake.
// Handshake: start is sampled only while idle (busy=0, done=0); the accepting edge
// latches dividend/divisor. done is a one-cycle pulse and quotient/remainder/
// div_by_zero are valid from that cycle on, holding until the next completion.
// busy and done are never high together.
module seq_divider #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // After every step the partial remainder is below the divisor, so its top
  // bit (bit N of the (N+1)-bit remainder) is always zero and is not stored.
  logic [N-1:0] r, r_nxt;
  logic [N-1:0] q, q_nxt;
  logic [N-1:0] dvsr, dvsr_nxt;
  logic [N-1:0] quo_nxt, rem_nxt;
  logic         dz_nxt;
  logic         busy_nxt, done_nxt;

  logic [N:0]   r_sh;
  logic [N:0]   t;
  logic         qbit;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  assign r_sh = {r, q[N-1]};
  assign t    = r_sh - {1'b0, dvsr};
  assign qbit = ~t[N];

  // Next-state, datapath and output decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    r_nxt     = r;
    q_nxt     = q;
    dvsr_nxt  = dvsr;
    quo_nxt   = quotient;
    rem_nxt   = remainder;
    dz_nxt    = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor != '0) begin
            q_nxt     = dividend;
            dvsr_nxt  = divisor;
            r_nxt     = '0;
            cnt_nxt   = '0;
            state_nxt = CALC;
          end else begin
            quo_nxt   = '1;
            rem_nxt   = dividend;
            dz_nxt    = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      CALC: begin
        r_nxt   = qbit ? t[N-1:0] : r_sh[N-1:0];
        q_nxt   = {q[N-2:0], qbit};
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST) begin
          quo_nxt   = {q[N-2:0], qbit};
          rem_nxt   = qbit ? t[N-1:0] : r_sh[N-1:0];
          dz_nxt    = 1'b0;
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    busy_nxt = (state_nxt == CALC);
    done_nxt = (state_nxt == DONE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dvsr        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      r           <= r_nxt;
      q           <= q_nxt;
      dvsr        <= dvsr_nxt;
      quotient    <= quo_nxt;
      remainder   <= rem_nxt;
      div_by_zero <= dz_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: directed cases, overlap/ignore cases, mid-run reset
// and a long back-to-back random run against an arithmetic reference model.
module tb_seq_divider;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  seq_divider #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    int           acc;
    int           due;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    end
  endtask

  // Reference model: plain arithmetic on the operands.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acc);
    exp_t m;
    m.a   = a;
    m.b   = b;
    m.acc = acc;
    if (b == '0) begin
      m.q   = '1;
      m.r   = a;
      m.dz  = 1'b1;
      m.due = acc;
    end else begin
      m.q   = a / b;
      m.r   = a % b;
      m.dz  = 1'b0;
      m.due = acc + N;
    end
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  // Call at a negedge while the DUT is idle; returns the accepting edge index.
  task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b, output int acc);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q.push_back(model(a, b, acc));
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < N + 8 && exp_q.size() != 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      chk("done_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic do_div(input logic [N-1:0] a, input logic [N-1:0] b);
    int acc;
    @(negedge clk);
    drive_start(a, b, acc);
    wait_idle();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic exp_busy;
    logic exp_done;
    if (rst_n) begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        if (!e.dz && cyc >= e.acc && cyc <= e.acc + N - 1) exp_busy = 1'b1;
        if (cyc == e.due) exp_done = 1'b1;
      end
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("done", 64'(done), 64'(exp_done));
      if (busy && done) chk("busy_and_done", 64'd1, 64'd0);
      if (exp_done) begin
        e = exp_q.pop_front();
        held = e;
        if (!e.dz) begin
          chk("invariant", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
          chk("rem_lt_div", 64'(remainder < e.b), 64'd1);
        end
      end
      chk("quotient", 64'(quotient), 64'(held.q));
      chk("remainder", 64'(remainder), 64'(held.r));
      chk("div_by_zero", 64'(div_by_zero), 64'(held.dz));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int acc;
    int acc2;
    int nxt;
    int sel;
    logic [N-1:0] a;
    logic [N-1:0] b;

    held     = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #3;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_quotient", 64'(quotient), 64'd0);
    chk("rst_remainder", 64'(remainder), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases including boundary operands and divide by zero.
    do_div(32'd100, 32'd7);
    do_div(32'hFFFF_FFFF, 32'd1);
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_div(32'd3, 32'd10);
    do_div(32'd5, 32'd0);
    do_div(32'd0, 32'd9);

    // Start during CALC and operand changes are ignored; next accept at edge 34.
    @(negedge clk);
    drive_start(32'd1000, 32'd3, acc);
    while (cyc < acc + 9) @(negedge clk);
    dividend = 32'd9;
    divisor  = 32'd9;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      dividend = $urandom;
      divisor  = $urandom;
      @(negedge clk);
    end
    while (cyc < acc + 33) @(negedge clk);
    drive_start(32'd77, 32'd8, acc2);
    wait_idle();

    // Reset during CALC step 15 aborts with no done pulse.
    @(negedge clk);
    drive_start(32'd123457, 32'd5, acc);
    while (cyc < acc + 15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    held = '0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_quotient", 64'(quotient), 64'd0);
    chk("abort_remainder", 64'(remainder), 64'd0);
    chk("abort_dz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    do_div(32'd42, 32'd6);

    // Back-to-back: start held high, operands change right after each accept.
    @(negedge clk);
    nxt = cyc + 1;
    for (int i = 0; i < 1000; i++) begin
      sel = $urandom_range(0, 7);
      a = (sel[0]) ? $urandom : 32'($urandom_range(0, 1000));
      case (sel)
        0: b = '0;
        1: b = 32'($urandom_range(1, 16));
        2: b = '1;
        3: b = a;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      while (cyc < nxt) begin
        @(posedge clk);
        #1;
      end
      exp_q.push_back(model(a, b, nxt));
      nxt = nxt + ((b == '0) ? 2 : N + 2);
      dividend = $urandom;
      divisor  = $urandom;
    end
    while (cyc < nxt - 1) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the MAC datapath. It is the inverse arithmetic path to the multiply-accumulate chain and is used for normalisation and scaling of accumulated results. Each step shift-subtracts one quotient bit using the same ripple-subtract arithmetic as the datapath adders. A start/done handshake wraps the datapath, so the MAC controller can issue one division and collect the quotient and remainder N cycles later.

## Interface
- N, 32, operand width in bits (N ≥ 2).
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  N  unsigned dividend; latched when start is accepted.
- divisor  input  N  unsigned divisor; latched when start is accepted.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  N  unsigned quotient.
- remainder  output  N  unsigned remainder.
- div_by_zero  output  1  set with done when the latched divisor was 0.

## Operation
- States: IDLE, CALC, DONE. Reset state is IDLE.
- Reset values: busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Internal counter, partial remainder and shift registers are also 0.
- IDLE:
  - start=1 and divisor≠0: latch both operands, clear the (N+1)-bit partial remainder R, set step count to 0, go to CALC.
  - start=1 and divisor=0: go straight to DONE. Set quotient = all ones, remainder = dividend, div_by_zero=1.
  - start=0: stay in IDLE.
- CALC (one step per cycle, N steps):
  - R ← {R[N-1:0], Q[N-1]}, where Q is the dividend/quotient shift register.
  - T = R − {0, divisor}, computed N+1 bits wide.
  - If T[N]=0: R ← T and the quotient bit is 1. Otherwise R is kept and the quotient bit is 0.
  - Q ← {Q[N-2:0], qbit}.
  - After step N: quotient ← Q, remainder ← R[N-1:0], div_by_zero ← 0, go to DONE.
- DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
- start is ignored in CALC and DONE. It is not queued, and no operand is re-latched.
- Changes on dividend or divisor after the accepting edge have no effect on the operation in flight.
- quotient, remainder and div_by_zero hold their values until the next DONE entry. They are not cleared on return to IDLE.
- Invariant for every nonzero divisor: dividend = quotient·divisor + remainder, and remainder < divisor.
- Reset asserted mid-CALC aborts the operation immediately: all outputs return to their reset values and there is no done pulse. After rst_n deasserts, the block is in IDLE and accepts start on the first edge.

## Timing
- Edge 0 is the edge that accepts start.
- Normal division:
  - busy is high from edge 0 to edge N.
  - done and valid results appear after edge N, so latency is N cycles.
  - done falls after edge N+1.
  - Earliest next accept is edge N+2, which gives a throughput of one division per N+2 cycles.
- Divide by zero: done, div_by_zero and results appear after edge 0 (latency 1). busy never rises. Earliest next accept is edge 2.
- done and busy are never high in the same cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then dividend=100, divisor=7, start for one cycle (N=32) -> busy for 32 cycles, done after edge 32, quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0. Then dividend=0xFFFFFFFF, divisor=0xFFFFFFFF -> quotient=1, remainder=0. Then dividend=3, divisor=10 -> quotient=0, remainder=3.
- dividend=5, divisor=0 -> done after edge 0, div_by_zero=1, quotient=0xFFFFFFFF, remainder=5, busy stays 0.
- Start 1000/3, then pulse start with 9/9 at edge 10 and change both operands during CALC -> only one done, quotient=333, remainder=1. A start at edge 34 (IDLE) is accepted.
- Assert rst_n=0 at CALC step 15 -> all outputs 0 asynchronously and no done pulse. Release and start 42/6 -> quotient=7, remainder=0 after 32 cycles.
- Back-to-back: start held high continuously with random operands for 1000 operations -> each result satisfies the invariant, and the accept spacing is exactly N+2 cycles (2 for divide-by-zero).
